// File: rtl/counter_chain_ctrl.sv
// Sequencer for a pair of chained 32-bit counters: loads, starts, stops, and
// takes tear-free 64-bit snapshots by re-reading the high word.
module counter_chain_ctrl #(
    parameter int MAX_RETRY = 3
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [63:0] cmd_period,
    input  logic [2:0]  cmd_mode,
    output logic        rsp_valid,
    output logic [63:0] rsp_value,
    output logic        rsp_err,
    output logic        lo_cfg_we,
    output logic        hi_cfg_we,
    output logic [3:0]  lo_val_we,
    output logic [3:0]  hi_val_we,
    output logic [3:0]  lo_dat_we,
    output logic [3:0]  hi_dat_we,
    output logic [31:0] lo_di,
    output logic [31:0] hi_di,
    input  logic [31:0] lo_dat_do,
    input  logic [31:0] hi_dat_do
);

    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [RW-1:0] MAX_R = RW'(MAX_RETRY);

    localparam logic [1:0] OP_LOAD  = 2'd0;
    localparam logic [1:0] OP_START = 2'd1;
    localparam logic [1:0] OP_STOP  = 2'd2;
    localparam logic [1:0] OP_SNAP  = 2'd3;

    typedef enum logic [3:0] {
        IDLE, LD_CFG, LD_VAL, LD_DAT, ST_HI, ST_LO, SP_LO, SP_HI,
        RD_H1, RD_L, RD_H2, RSP
    } state_t;

    state_t        state_q, state_d;
    logic [63:0]   period_q, period_d;
    logic [2:0]    mode_q, mode_d;
    logic [RW-1:0] retry_q, retry_d;
    logic [31:0]   h1_q, h1_d, l_q, l_d;
    logic          lo_cfg_we_q, lo_cfg_we_d, hi_cfg_we_q, hi_cfg_we_d;
    logic [3:0]    lo_val_we_q, lo_val_we_d, hi_val_we_q, hi_val_we_d;
    logic [3:0]    lo_dat_we_q, lo_dat_we_d, hi_dat_we_q, hi_dat_we_d;
    logic [31:0]   lo_di_q, lo_di_d, hi_di_q, hi_di_d;
    logic          rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
    logic [63:0]   rsp_value_q, rsp_value_d;

    // mode is {irq_ena, updown, oneshot}; irq_ena only ever lands in the high word
    function automatic logic [31:0] cfg_word(input logic [2:0] m, input logic hi_word,
                                             input logic en);
        return {27'd0, hi_word & m[2], 1'b1, m[1], m[0], en};
    endfunction

    assign cmd_ready = (state_q == IDLE) && !wb_rst_i;

    always_comb begin
        state_d     = state_q;
        period_d    = period_q;
        mode_d      = mode_q;
        retry_d     = retry_q;
        h1_d        = h1_q;
        l_d         = l_q;
        lo_cfg_we_d = 1'b0;
        hi_cfg_we_d = 1'b0;
        lo_val_we_d = 4'h0;
        hi_val_we_d = 4'h0;
        lo_dat_we_d = 4'h0;
        hi_dat_we_d = 4'h0;
        lo_di_d     = lo_di_q;
        hi_di_d     = hi_di_q;
        rsp_valid_d = 1'b0;
        rsp_value_d = rsp_value_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    case (cmd_op)
                        OP_LOAD: begin
                            state_d     = LD_CFG;
                            period_d    = cmd_period;
                            mode_d      = cmd_mode;
                            lo_cfg_we_d = 1'b1;
                            hi_cfg_we_d = 1'b1;
                            lo_di_d     = 32'd0;
                            hi_di_d     = 32'd0;
                        end
                        OP_START: begin
                            state_d     = ST_HI;
                            hi_cfg_we_d = 1'b1;
                            hi_di_d     = cfg_word(mode_q, 1'b1, 1'b1);
                        end
                        OP_STOP: begin
                            state_d     = SP_LO;
                            lo_cfg_we_d = 1'b1;
                            lo_di_d     = cfg_word(mode_q, 1'b0, 1'b0);
                        end
                        OP_SNAP: begin
                            state_d = RD_H1;
                            retry_d = '0;
                        end
                        default: state_d = IDLE;
                    endcase
                end
            end
            LD_CFG: begin
                state_d     = LD_VAL;
                lo_val_we_d = 4'hF;
                hi_val_we_d = 4'hF;
                lo_di_d     = period_q[31:0];
                hi_di_d     = period_q[63:32];
            end
            LD_VAL: begin
                // up-counters start from zero, down-counters from the period
                state_d     = LD_DAT;
                lo_dat_we_d = 4'hF;
                hi_dat_we_d = 4'hF;
                lo_di_d     = mode_q[1] ? 32'd0 : period_q[31:0];
                hi_di_d     = mode_q[1] ? 32'd0 : period_q[63:32];
            end
            ST_HI: begin
                state_d     = ST_LO;
                lo_cfg_we_d = 1'b1;
                lo_di_d     = cfg_word(mode_q, 1'b0, 1'b1);
            end
            SP_LO: begin
                state_d     = SP_HI;
                hi_cfg_we_d = 1'b1;
                hi_di_d     = cfg_word(mode_q, 1'b1, 1'b0);
            end
            RD_H1: begin
                state_d = RD_L;
                h1_d    = hi_dat_do;
            end
            RD_L: begin
                state_d = RD_H2;
                l_d     = lo_dat_do;
            end
            RD_H2: begin
                if (hi_dat_do == h1_q) begin
                    state_d     = RSP;
                    rsp_valid_d = 1'b1;
                    rsp_value_d = {h1_q, l_q};
                    rsp_err_d   = 1'b0;
                end else if (retry_q < MAX_R) begin
                    state_d = RD_H1;
                    retry_d = retry_q + RW'(1);
                end else begin
                    state_d     = RSP;
                    rsp_valid_d = 1'b1;
                    rsp_value_d = {hi_dat_do, l_q};
                    rsp_err_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q     <= IDLE;
            period_q    <= 64'd0;
            mode_q      <= 3'd0;
            retry_q     <= '0;
            h1_q        <= 32'd0;
            l_q         <= 32'd0;
            lo_cfg_we_q <= 1'b0;
            hi_cfg_we_q <= 1'b0;
            lo_val_we_q <= 4'h0;
            hi_val_we_q <= 4'h0;
            lo_dat_we_q <= 4'h0;
            hi_dat_we_q <= 4'h0;
            lo_di_q     <= 32'd0;
            hi_di_q     <= 32'd0;
            rsp_valid_q <= 1'b0;
            rsp_value_q <= 64'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            period_q    <= period_d;
            mode_q      <= mode_d;
            retry_q     <= retry_d;
            h1_q        <= h1_d;
            l_q         <= l_d;
            lo_cfg_we_q <= lo_cfg_we_d;
            hi_cfg_we_q <= hi_cfg_we_d;
            lo_val_we_q <= lo_val_we_d;
            hi_val_we_q <= hi_val_we_d;
            lo_dat_we_q <= lo_dat_we_d;
            hi_dat_we_q <= hi_dat_we_d;
            lo_di_q     <= lo_di_d;
            hi_di_q     <= hi_di_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_value_q <= rsp_value_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign lo_cfg_we = lo_cfg_we_q;
    assign hi_cfg_we = hi_cfg_we_q;
    assign lo_val_we = lo_val_we_q;
    assign hi_val_we = hi_val_we_q;
    assign lo_dat_we = lo_dat_we_q;
    assign hi_dat_we = hi_dat_we_q;
    assign lo_di     = lo_di_q;
    assign hi_di     = hi_di_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_value = rsp_value_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_counter_chain_ctrl.sv
// Directed plus randomized bench for counter_chain_ctrl with a cycle-level
// reference model of the load/start/stop/snapshot command behaviour.
module tb_counter_chain_ctrl;

    localparam int MAXR = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'd0;
    logic [63:0] cmd_period = 64'd0;
    logic [2:0]  cmd_mode = 3'd0;
    logic        rsp_valid;
    logic [63:0] rsp_value;
    logic        rsp_err;
    logic        lo_cfg_we, hi_cfg_we;
    logic [3:0]  lo_val_we, hi_val_we, lo_dat_we, hi_dat_we;
    logic [31:0] lo_di, hi_di;
    logic [31:0] lo_dat_do = 32'd0;
    logic [31:0] hi_dat_do = 32'd0;

    int errors = 0;
    int checks = 0;
    logic [2:0]  mode_m = 3'd0;
    logic [63:0] last_rsp = 64'd0;
    logic [31:0] hi_seq [0:15];
    logic [31:0] lo_seq [0:15];

    counter_chain_ctrl #(.MAX_RETRY(MAXR)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_period(cmd_period), .cmd_mode(cmd_mode),
        .rsp_valid(rsp_valid), .rsp_value(rsp_value), .rsp_err(rsp_err),
        .lo_cfg_we(lo_cfg_we), .hi_cfg_we(hi_cfg_we),
        .lo_val_we(lo_val_we), .hi_val_we(hi_val_we),
        .lo_dat_we(lo_dat_we), .hi_dat_we(hi_dat_we),
        .lo_di(lo_di), .hi_di(hi_di),
        .lo_dat_do(lo_dat_do), .hi_dat_do(hi_dat_do)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [17:0] stb();
        return {lo_cfg_we, hi_cfg_we, lo_val_we, hi_val_we, lo_dat_we, hi_dat_we};
    endfunction

    // Control word from the documented bit map: en, oneshot, updown, chain, irq.
    function automatic logic [31:0] cfg_exp(input logic [2:0] m, input bit hi_word, input bit en);
        int v;
        v = (en ? 1 : 0) + (m[0] ? 2 : 0) + (m[1] ? 4 : 0) + 8 + ((hi_word && m[2]) ? 16 : 0);
        return 32'(v);
    endfunction

    task automatic issue(input logic [1:0] op, input logic [63:0] per, input logic [2:0] md);
        cmd_valid  = 1'b1;
        cmd_op     = op;
        cmd_period = per;
        cmd_mode   = md;
        @(posedge clk);
    endtask

    task automatic do_load(input logic [63:0] per, input logic [2:0] md);
        issue(2'd0, per, md);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("load_cfg_stb", stb(), {2'b11, 16'h0});
        chk("load_cfg_di", {hi_di, lo_di}, 64'd0);
        chk("load_busy", cmd_ready, 1'b0);
        @(negedge clk);
        chk("load_val_stb", stb(), {2'b00, 8'hFF, 8'h00});
        chk("load_val_di", {hi_di, lo_di}, per);
        @(negedge clk);
        chk("load_dat_stb", stb(), {2'b00, 8'h00, 8'hFF});
        chk("load_dat_di", {hi_di, lo_di}, md[1] ? 64'd0 : per);
        @(negedge clk);
        chk("load_done_stb", stb(), 18'd0);
        chk("load_ready", cmd_ready, 1'b1);
        mode_m = md;
    endtask

    task automatic do_start_stop(input bit start);
        issue(start ? 2'd1 : 2'd2, {$urandom, $urandom}, 3'($urandom_range(0, 7)));
        @(negedge clk);
        cmd_valid = 1'b0;
        if (start) begin
            chk("start_hi_stb", stb(), {2'b01, 16'h0});
            chk("start_hi_di", hi_di, cfg_exp(mode_m, 1, 1));
        end else begin
            chk("stop_lo_stb", stb(), {2'b10, 16'h0});
            chk("stop_lo_di", lo_di, cfg_exp(mode_m, 0, 0));
        end
        @(negedge clk);
        if (start) begin
            chk("start_lo_stb", stb(), {2'b10, 16'h0});
            chk("start_lo_di", lo_di, cfg_exp(mode_m, 0, 1));
        end else begin
            chk("stop_hi_stb", stb(), {2'b01, 16'h0});
            chk("stop_hi_di", hi_di, cfg_exp(mode_m, 1, 0));
        end
        @(negedge clk);
        chk("ss_done_stb", stb(), 18'd0);
        chk("ss_ready", cmd_ready, 1'b1);
    endtask

    // hi_seq[k]/lo_seq[k] are the counter values presented at the k-th edge after accept.
    task automatic do_snap();
        int lat;
        logic [63:0] ev;
        logic ee;
        bit done;
        lat = 0; ev = 64'd0; ee = 1'b0; done = 0;
        for (int p = 0; p <= MAXR; p++) begin
            if (!done) begin
                if (hi_seq[1 + 3*p] == hi_seq[3 + 3*p]) begin
                    ev = {hi_seq[1 + 3*p], lo_seq[2 + 3*p]}; ee = 1'b0;
                    lat = 4 + 3*p; done = 1;
                end else if (p == MAXR) begin
                    ev = {hi_seq[3 + 3*p], lo_seq[2 + 3*p]}; ee = 1'b1;
                    lat = 4 + 3*p; done = 1;
                end
            end
        end
        issue(2'd3, 64'd0, 3'd0);
        for (int k = 1; k <= lat + 1; k++) begin
            @(negedge clk);
            if (k == 1) cmd_valid = 1'b0;
            if (k < lat) begin
                chk("snap_wait_valid", rsp_valid, 1'b0);
                chk("snap_wait_stb", stb(), 18'd0);
            end else if (k == lat) begin
                chk("snap_valid", rsp_valid, 1'b1);
                chk("snap_value", rsp_value, ev);
                chk("snap_err", rsp_err, ee);
            end else begin
                chk("snap_pulse_end", rsp_valid, 1'b0);
                chk("snap_hold", rsp_value, ev);
                chk("snap_ready", cmd_ready, 1'b1);
            end
            if (k < 16) begin
                hi_dat_do = hi_seq[k];
                lo_dat_do = lo_seq[k];
            end
        end
        last_rsp = ev;
    endtask

    task automatic fill_snap(input int kind);
        logic [31:0] base;
        base = $urandom;
        for (int k = 0; k < 16; k++) begin
            lo_seq[k] = $urandom;
            case (kind)
                0: hi_seq[k] = base;
                1: hi_seq[k] = base + 32'($urandom_range(0, 1));
                default: hi_seq[k] = base + 32'(k);
            endcase
        end
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_stb"}, stb(), 18'd0);
        chk({tag, "_di"}, {hi_di, lo_di}, 64'd0);
        chk({tag, "_rsp"}, {rsp_valid, rsp_err, rsp_value}, 66'd0);
    endtask

    initial begin
        // reset
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ready", cmd_ready, 1'b0);
        check_reset_state("rst");
        rst = 1'b0;
        @(negedge clk);
        chk("rst_release_ready", cmd_ready, 1'b1);

        // START with no prior LOAD uses mode 0
        do_start_stop(1);

        do_load(64'h0000_0002_0000_0010, 3'b000);
        do_load(64'h0000_0003_0000_0040, 3'b110);
        do_start_stop(1);
        do_start_stop(0);

        for (int k = 0; k < 16; k++) begin
            hi_seq[k] = 32'h5;
            lo_seq[k] = 32'h1234;
        end
        do_snap();
        chk("snap_fixed_value", last_rsp, 64'h0000_0005_0000_1234);

        fill_snap(2);
        do_snap();

        // STOP with a command left asserted while busy: it must not be queued
        issue(2'd2, 64'd0, 3'd0);
        @(negedge clk);
        cmd_op = 2'd1;
        chk("busy_stop_lo", stb(), {2'b10, 16'h0});
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("busy_stop_hi", stb(), {2'b01, 16'h0});
        repeat (2) begin
            @(negedge clk);
            chk("busy_ignored", stb(), 18'd0);
        end

        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(0, 3))
                0: do_load({$urandom, $urandom}, 3'($urandom_range(0, 7)));
                1: do_start_stop(1);
                2: do_start_stop(0);
                default: begin
                    fill_snap(int'($urandom_range(0, 2)));
                    do_snap();
                end
            endcase
        end

        // reset during LD_VAL aborts the load
        issue(2'd0, 64'h1111_2222_3333_4444, 3'b101);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("abort_in_ldval", stb(), {2'b00, 8'hFF, 8'h00});
        rst = 1'b1;
        @(negedge clk);
        chk("abort_ready_low", cmd_ready, 1'b0);
        check_reset_state("abort_load");
        rst = 1'b0;
        @(negedge clk);
        chk("abort_ready", cmd_ready, 1'b1);
        check_reset_state("abort_load_after");
        mode_m = 3'd0;
        do_start_stop(1);

        // reset during a snapshot: no response ever
        fill_snap(2);
        issue(2'd3, 64'd0, 3'd0);
        @(negedge clk);
        cmd_valid = 1'b0;
        hi_dat_do = hi_seq[1];
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            hi_dat_do = hi_seq[k];
            chk("abort_snap_quiet", {rsp_valid, stb()}, 19'd0);
        end
        chk("abort_snap_value", rsp_value, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/counter_chain_ctrl.md
COUNTER_CHAIN_CTRL -- requirements
Module: counter_chain_ctrl

Interface
REQ-001 SHALL have parameter MAX_RETRY, default 3, maximum re-reads in a 64-bit snapshot before an error response.
REQ-002 SHALL use a single clock and a synchronous, active-high reset: wb_clk_i  in  1  clock; wb_rst_i  in  1  reset.
REQ-003 SHALL have cmd_valid  in  1  command request; cmd_ready  out  1  command accepted when both high.
REQ-004 SHALL have cmd_op  in  2  command: 0 LOAD, 1 START, 2 STOP, 3 SNAP.
REQ-005 SHALL have cmd_period  in  64  terminal/reload value; cmd_mode  in  3  {irq_ena, updown, oneshot}.
REQ-006 SHALL have rsp_valid  out  1  one-cycle snapshot pulse; rsp_value  out  64  snapshot {hi,lo}; rsp_err  out  1  retries exhausted.
REQ-007 SHALL have lo_cfg_we/hi_cfg_we  out  1  cfg write strobes; lo_val_we/hi_val_we  out  4  reload byte strobes; lo_dat_we/hi_dat_we  out  4  current-value byte strobes.
REQ-008 SHALL have lo_di/hi_di  out  32  write data; lo_dat_do/hi_dat_do  in  32  current counter values.

Function
REQ-009 SHALL be FSM with states IDLE, LD_CFG, LD_VAL, LD_DAT, ST_HI, ST_LO, SP_LO, SP_HI, RD_H1, RD_L, RD_H2, RSP.
REQ-010 SHALL drive cmd_ready = 1 only in IDLE with wb_rst_i low; cmd_op/cmd_period/cmd_mode captured on the accepting edge.
REQ-011 SHALL register all strobe and data outputs; each strobe high for exactly one cycle; all strobes 0 in IDLE, RD_*, RSP.
REQ-012 LOAD: LD_CFG writes both cfg = 0; LD_VAL writes both val (we=4'hF) = period halves; LD_DAT writes both dat (we=4'hF) = period halves if updown=0, else 0; then IDLE; stored mode updated from cmd_mode.
REQ-013 LOAD SHALL occupy cycles A+1..A+3 after accept edge A, cmd_ready high again at A+4.
REQ-014 START: ST_HI writes hi cfg = {irq_ena,1,updown,oneshot,1}; next cycle ST_LO writes lo cfg = {0,1,updown,oneshot,1}; then IDLE; uses stored mode.
REQ-015 STOP: SP_LO writes lo cfg = {0,1,updown,oneshot,0}; next cycle SP_HI writes hi cfg = {irq_ena,1,updown,oneshot,0}; low word always stopped before high.
REQ-016 cfg data bit map: [0] enable, [1] oneshot, [2] updown, [3] chain, [4] irq_ena, [31:5] = 0.
REQ-017 SNAP: RD_H1 latches hi_dat_do as H1; RD_L latches lo_dat_do as L; RD_H2 compares hi_dat_do to H1.
REQ-018 If equal: RSP with rsp_value = {H1,L}, rsp_err = 0.
REQ-019 If unequal and retry count < MAX_RETRY: increment count, return to RD_H1.
REQ-020 If unequal and count = MAX_RETRY: RSP with rsp_value = {hi_dat_do at RD_H2, L}, rsp_err = 1.
REQ-021 rsp_valid SHALL be high exactly one cycle (RSP), then IDLE; rsp_value/rsp_err hold until next RSP; retry count cleared on SNAP accept.
REQ-022 Best-case SNAP latency: accept edge A, rsp_valid in cycle A+4.
REQ-023 START/STOP/SNAP with no prior LOAD SHALL proceed using stored mode (reset value 0).
REQ-024 cmd_valid while busy SHALL be ignored (no queueing); command held until cmd_ready.

Reset
REQ-025 wb_rst_i high at a clock edge SHALL set state IDLE, all strobes 0, lo_di/hi_di 0, stored mode 0, retry count 0, rsp_valid 0, rsp_value 0, rsp_err 0.
REQ-026 Reset mid-sequence SHALL abort it: no further strobes after the reset edge, no rsp_valid for the aborted SNAP.
REQ-027 cmd_ready SHALL be 0 while wb_rst_i is high and 1 in the first cycle after it falls.

Verification
REQ-028 LOAD period=64'h0000_0002_0000_0010, mode=3'b000 -> cfg=0 both; lo val 32'h10, hi val 32'h2; dat lo 32'h10, hi 32'h2; cmd_ready back at A+4.
REQ-029 LOAD mode=3'b110 then START -> dat writes 0 both; hi cfg 32'h1D one cycle before lo cfg 32'h0D.
REQ-030 STOP after REQ-029 -> lo cfg 32'h0C, next cycle hi cfg 32'h1C.
REQ-031 SNAP, hi stable 32'h5, lo 32'h1234 -> rsp_value 64'h0000_0005_0000_1234, rsp_err 0, rsp_valid at A+4.
REQ-032 SNAP, hi changes between RD_H1 and RD_H2 on every pass -> MAX_RETRY+1 passes, then rsp_err 1.
REQ-033 wb_rst_i asserted during LD_VAL -> no LD_DAT strobes, outputs 0, cmd_ready 1 cycle after release.
